toggle_period_meter: RTL and testbench

Measures the half-period of an externally driven toggle signal, such as the blink output of a divided-down counter, in `sys_clk` cycles. It is the receive side of the team's counter/toggle generators:
- synchronises the incoming level;
- detects each transition;
- counts clock cycles between consecutive transitions;
- publishes each result with a one-cycle valid strobe;
- flags a timeout when transitions stop.

---
 rtl/toggle_meter_pkg.sv | 14 +
 rtl/sync_edge_det.sv | 29 ++
 rtl/toggle_period_meter.sv | 138 +++++++++++++
 tb/tb_toggle_period_meter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/toggle_meter_pkg.sv
// Shared types for the toggle period meter: FSM state type and its encoding.
package toggle_meter_pkg;

  localparam logic [1:0] ST_IDLE_ENC = 2'b00;
  localparam logic [1:0] ST_MEAS_ENC = 2'b01;
  localparam logic [1:0] ST_TOUT_ENC = 2'b10;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE_ENC,
    MEAS = ST_MEAS_ENC,
    TOUT = ST_TOUT_ENC
  } meter_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser plus history flop; sig_edge flags any level change
// of an asynchronous input, one sys_clk cycle wide.
module sync_edge_det (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic async_in,
  output logic sig_edge
);

  logic s1;
  logic s2;
  logic s3;

  // Reset to 0 so a high input after reset is seen as a rising transition.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sig_edge = s2 ^ s3;

endmodule

// File: rtl/toggle_period_meter.sv
// Measures the half-period of an asynchronous toggle input in sys_clk cycles,
// with a valid strobe and a timeout flag. Optional macro EXPECT_CHECK_EN adds
// period_err, a tolerance check of each measurement against EXP_HALF.
module toggle_period_meter
  import toggle_meter_pkg::*;
#(
  parameter int               CNT_W   = 25,
  parameter logic [CNT_W-1:0] TIMEOUT = 25'd100
`ifdef EXPECT_CHECK_EN
  ,
  parameter logic [CNT_W-1:0] EXP_HALF = 25'd25,
  parameter logic [CNT_W-1:0] TOL      = 25'd1
`endif
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] half_period,
  output logic             meas_valid,
  output logic             timeout
`ifdef EXPECT_CHECK_EN
  ,
  output logic             period_err
`endif
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  meter_state_t     state;
  meter_state_t     state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] half_nxt;
  logic             valid_nxt;
  logic             timeout_nxt;
  logic             sig_edge;

  sync_edge_det u_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .async_in  (sig_in),
    .sig_edge  (sig_edge)
  );

  assign cnt_inc = cnt + ONE;

`ifdef EXPECT_CHECK_EN
  logic [CNT_W:0] diff;
  logic [CNT_W:0] abs_diff;
  logic           out_of_tol;
  logic           err_nxt;

  // One spare bit so the sign of (measured - expected) survives the subtract.
  always_comb begin
    diff       = {1'b0, cnt_inc} - {1'b0, EXP_HALF};
    abs_diff   = diff[CNT_W] ? (~diff + 1'b1) : diff;
    out_of_tol = (abs_diff > {1'b0, TOL});
  end
`endif

  // Next-state and registered-output logic; an edge always beats the timeout.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    half_nxt    = half_period;
    valid_nxt   = 1'b0;
    timeout_nxt = timeout;
`ifdef EXPECT_CHECK_EN
    err_nxt     = period_err;
`endif
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (sig_edge) begin
          state_nxt = MEAS;
        end
      end
      MEAS: begin
        cnt_nxt = cnt_inc;
        if (sig_edge) begin
          half_nxt  = cnt_inc;
          valid_nxt = 1'b1;
          cnt_nxt   = '0;
`ifdef EXPECT_CHECK_EN
          err_nxt   = out_of_tol;
`endif
        end else if (cnt == TIMEOUT - ONE) begin
          state_nxt   = TOUT;
          timeout_nxt = 1'b1;
          cnt_nxt     = cnt;
`ifdef EXPECT_CHECK_EN
          err_nxt     = 1'b1;
`endif
        end
      end
      TOUT: begin
        // The interval that ends here began before the timeout, so no strobe.
        if (sig_edge) begin
          state_nxt   = MEAS;
          cnt_nxt     = '0;
          timeout_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      half_period <= '0;
      meas_valid  <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      half_period <= half_nxt;
      meas_valid  <= valid_nxt;
      timeout     <= timeout_nxt;
    end
  end

`ifdef EXPECT_CHECK_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      period_err <= 1'b0;
    end else begin
      period_err <= err_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_toggle_period_meter.sv
// Directed bench for toggle_period_meter: table of toggle gaps with
// hand-computed results, plus timeout, exact-strobe and async-reset sequences.
module tb_toggle_period_meter;

  localparam int CNT_W = 25;

  logic             sys_clk;
  logic             sys_rst_n;
  logic             sig_in;
  logic [CNT_W-1:0] half_period;
  logic             meas_valid;
  logic             timeout;
`ifdef EXPECT_CHECK_EN
  logic             period_err;
`endif

  int compared;
  int mismatched;
  int strobe_cnt;

  typedef struct {
    string name;
    int    gap;
    int    n_toggles;
    int    exp_strobes;
    int    exp_half;
    int    exp_timeout;
    int    exp_err;
  } vec_t;

  vec_t vecs[7];

  toggle_period_meter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (25'd100)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .sig_in      (sig_in),
    .half_period (half_period),
    .meas_valid  (meas_valid),
    .timeout     (timeout)
`ifdef EXPECT_CHECK_EN
    ,
    .period_err  (period_err)
`endif
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Advance n falling edges, counting strobes seen at each sample point.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      if (meas_valid) strobe_cnt++;
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic do_reset();
    sig_in    = 1'b0;
    sys_rst_n = 1'b0;
    tick(2);
    sys_rst_n = 1'b1;
    tick(1);
    strobe_cnt = 0;
  endtask

  // Reset, then toggle sig_in n times, gap cycles apart, and let the pipe drain.
  task automatic applyStimulus(input int gap, input int n);
    do_reset();
    for (int i = 0; i < n; i++) begin
      sig_in = ~sig_in;
      if (i < n - 1) tick(gap);
    end
    tick(4);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    strobe_cnt = 0;
    sig_in     = 1'b0;
    sys_rst_n  = 1'b0;

    //          name        gap  n  strobes half tout err
    vecs[0] = '{"gap25",     25, 4, 3,      25,  0,   0};
    vecs[1] = '{"gap27",     27, 3, 2,      27,  0,   1};
    vecs[2] = '{"gap24",     24, 3, 2,      24,  0,   0};
    vecs[3] = '{"gap1",       1, 6, 5,       1,  0,   1};
    vecs[4] = '{"gap2",       2, 4, 3,       2,  0,   1};
    vecs[5] = '{"gap100",   100, 3, 2,     100,  0,   1};
    vecs[6] = '{"gap101",   101, 3, 0,       0,  0,   1};

    // Reset state
    sys_rst_n = 1'b0;
    tick(2);
    checkOutput("reset_half", int'(half_period), 0);
    checkOutput("reset_valid", int'(meas_valid), 0);
    checkOutput("reset_timeout", int'(timeout), 0);
`ifdef EXPECT_CHECK_EN
    checkOutput("reset_err", int'(period_err), 0);
`endif

    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].gap, vecs[v].n_toggles);
      checkOutput({vecs[v].name, "_strobes"}, strobe_cnt, vecs[v].exp_strobes);
      checkOutput({vecs[v].name, "_half"}, int'(half_period), vecs[v].exp_half);
      checkOutput({vecs[v].name, "_timeout"}, int'(timeout), vecs[v].exp_timeout);
`ifdef EXPECT_CHECK_EN
      checkOutput({vecs[v].name, "_err"}, int'(period_err), vecs[v].exp_err);
`endif
    end

    // Exact strobe timing and timeout after the signal stops
    do_reset();
    sig_in = ~sig_in;
    tick(25);
    sig_in = ~sig_in;
    tick(2);
    checkOutput("strobe_early", int'(meas_valid), 0);
    tick(1);
    checkOutput("strobe_on", int'(meas_valid), 1);
    checkOutput("strobe_half", int'(half_period), 25);
    tick(1);
    checkOutput("strobe_one_cycle", int'(meas_valid), 0);
    tick(98);
    checkOutput("timeout_not_yet", int'(timeout), 0);
    tick(1);
    checkOutput("timeout_at_100", int'(timeout), 1);
    checkOutput("timeout_keeps_half", int'(half_period), 25);
    tick(10);
    strobe_cnt = 0;
    sig_in = ~sig_in;
    tick(4);
    checkOutput("tout_exit_cleared", int'(timeout), 0);
    checkOutput("tout_exit_no_strobe", strobe_cnt, 0);
    tick(26);
    sig_in = ~sig_in;
    tick(4);
    checkOutput("after_tout_strobes", strobe_cnt, 1);
    checkOutput("after_tout_half", int'(half_period), 30);

    // Asynchronous reset in the middle of an interval
    do_reset();
    sig_in = ~sig_in;
    tick(20);
    sig_in = ~sig_in;
    tick(15);
    checkOutput("pre_reset_half", int'(half_period), 20);
    #2;
    sys_rst_n = 1'b0;
    sig_in    = 1'b0;
    #1;
    checkOutput("async_reset_half", int'(half_period), 0);
    checkOutput("async_reset_valid", int'(meas_valid), 0);
    checkOutput("async_reset_timeout", int'(timeout), 0);
    tick(2);
    sys_rst_n = 1'b1;
    tick(2);
    strobe_cnt = 0;
    sig_in = ~sig_in;
    tick(5);
    checkOutput("post_reset_first_edge", strobe_cnt, 0);
    tick(5);
    sig_in = ~sig_in;
    tick(4);
    checkOutput("post_reset_strobes", strobe_cnt, 1);
    checkOutput("post_reset_half", int'(half_period), 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
